i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- I2S receiver for the microphone data path.
- Consumes the SCK/WS pair produced by i2s_clock_gen (same clk_i domain) and the external serial data line.
- Deserialises MSB-first, Philips-format stereo words and presents one left/right sample pair per frame on a valid/ready interface to the downstream processing pipeline.

Parameters:
- DATA_W, 24, bits captured per channel (MSB-first); remaining slot bits ignored.
- SLOT_W, 32, SCK periods per channel slot (SCKS_PER_FRAME/2); legal range DATA_W..255.

Ports:
- clk_i  in  1  system clock (27 MHz)
- rst_i  in  1  synchronous, active-high reset
- sck_i  in  1  bit clock from i2s_clock_gen, synchronous to clk_i
- ws_i  in  1  word select from i2s_clock_gen (0 = left, 1 = right), synchronous to clk_i
- sd_i  in  1  serial data from microphone, asynchronous
- left_o  out  DATA_W  left sample of last completed frame
- right_o  out  DATA_W  right sample of last completed frame
- valid_o  out  1  sample pair available
- ready_i  in  1  consumer accepts pair when valid_o & ready_i
- overrun_o  out  1  one-cycle pulse: new pair overwrote an unaccepted pair
- frame_err_o  out  1  one-cycle pulse: channel slot ended with fewer than DATA_W bits captured

Behaviour:
- Reset values:
  - left_o = 0, right_o = 0, valid_o = 0, overrun_o = 0, frame_err_o = 0.
  - FSM in SYNC; bit counter = 0; shift register = 0; ws_prev = 1; sd synchroniser = 0.
- sd_i input:
  - Passes a 2-flop synchroniser (sd_s).
- SCK edge detection:
  - sck_q is registered sck_i.
  - A "rise cycle" is any cycle with sck_i=1 and sck_q=0.
  - All sampling happens in rise cycles only: sd_s and ws_i are sampled and ws_prev is updated with ws_i.
  - sd changes on the SCK falling edge; with SCK_DIV≥4, sd_s is stable at the rise cycle.
- WS change:
  - A rise cycle with ws_i != ws_prev is a WS-change edge.
  - Per I2S, the bit sampled on that edge is the LSB slot of the previous channel, so it is ignored.
  - The MSB is sampled on the next rise.
- FSM states:
  - SYNC: ignore data. On a WS-change edge with ws_i=0 (right→left), go to RUN and clear the bit counter. The partial frame present after reset is never output.
  - RUN, each non-change rise: if bit counter < DATA_W, shift sd_s into the shift register LSB-side. Increment the counter, saturating at 255.
  - RUN, WS-change edge: close the finished channel.
    - If counter ≥ DATA_W: shift register → left_hold (closing left) or right_o staging (closing right).
    - Else: pulse frame_err_o, mark the current frame bad.
    - Clear the counter and the shift register.
- Frame completion (right channel closed, ws_i=0 edge, frame not bad):
  - Next cycle: left_o ← left_hold, right_o ← captured right, valid_o=1.
  - If valid_o was already 1 and ready_i=0 in the completion cycle: pulse overrun_o together with the overwrite.
  - The bad-frame flag clears at each left start.
- Handshake:
  - valid_o and the data outputs hold stable until valid_o & ready_i.
  - valid_o deasserts the cycle after acceptance, unless a completion occurs in that same cycle. In that case valid_o stays 1 with the new data and there is no overrun.
- Latency: valid_o rises 1 clk after the rise cycle of the right→left WS-change edge.
- No counter overflow: a slot longer than SLOT_W keeps the first DATA_W bits; saturation prevents wrap.
- rst_i mid-frame: everything returns to reset values next cycle; resynchronisation is required via SYNC.
- ws_i toggling twice within DATA_W bits: frame_err_o pulses on each short slot; no valid_o for that frame.

Test Plan:
1. Clock gen SCK_DIV=8, SCKS_PER_FRAME=64. Bench drives left 0xA5A5A5, right 0x5A5A5A after a flushed first frame -> exactly one valid_o, left_o=0xA5A5A5, right_o=0x5A5A5A, valid_o 1 clk after the ws 1→0 rise; frame_err_o and overrun_o stay 0.
2. Release reset mid-right-slot with ready_i=1 -> no valid_o for that partial frame; first valid_o carries the first complete frame's data.
3. ready_i held 0 over two frames (0x111111/0x222222, then 0x333333/0x444444) -> overrun_o pulses once at the second completion; outputs show 0x333333/0x444444 and stay stable until ready_i=1.
4. ready_i=1 coinciding with a completion cycle -> valid_o stays 1, new data loaded, overrun_o=0.
5. Bench forces ws_i to toggle after 10 bits in the left slot -> frame_err_o pulses for 1 cycle; no valid_o for that frame; the following clean frame is received correctly.
6. Assert rst_i for 1 cycle mid-left-slot -> all outputs 0 next cycle; reception resumes only after the next right→left WS edge.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S receiver: deserialises Philips-format, MSB-first stereo words clocked by
// an in-domain SCK/WS pair and hands out one left/right pair per frame on a
// valid/ready interface, flagging short slots and overwritten pairs.
module i2s_rx #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sck_i,
  input  logic              ws_i,
  input  logic              sd_i,
  output logic [DATA_W-1:0] left_o,
  output logic [DATA_W-1:0] right_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              overrun_o,
  output logic              frame_err_o
);

  // Bit counter is 8 bits and saturates, so an overlong slot can never wrap
  // back below DATA_W and be mistaken for a short one.
  localparam logic [7:0] CNT_MAX = 8'd255;
  localparam logic [7:0] DATA_N  = 8'(DATA_W);

  generate
    if (SLOT_W < DATA_W || SLOT_W > 255) begin : g_bad_slot
      $error("i2s_rx: SLOT_W must lie in DATA_W..255");
    end
  endgenerate

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } pair_t;

  state_t            state_q, state_d;
  logic              sd_m, sd_s;
  logic              sck_q;
  logic              ws_prev;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] left_hold;
  logic              bad;
  pair_t             pair_q;

  logic rise, ws_edge, left_start;
  logic clear, step, shift_en;
  logic close_left, close_right, short_slot, complete;

  // SCK rising edge seen in the clk domain; all sampling is gated on it.
  assign rise       = sck_i & ~sck_q;
  // WS change on a rise: the bit on this edge is the old channel's LSB slot.
  assign ws_edge    = rise & (ws_i != ws_prev);
  assign left_start = ws_edge & ~ws_i;

  // Input synchroniser, SCK edge history and WS history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sd_m    <= 1'b0;
      sd_s    <= 1'b0;
      sck_q   <= 1'b0;
      ws_prev <= 1'b1;
    end else begin
      sd_m  <= sd_i;
      sd_s  <= sd_m;
      sck_q <= sck_i;
      if (rise) ws_prev <= ws_i;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= SYNC;
    else       state_q <= state_d;
  end

  // Next state and per-rise control strobes.
  always_comb begin
    state_d     = state_q;
    clear       = 1'b0;
    step        = 1'b0;
    close_left  = 1'b0;
    close_right = 1'b0;
    short_slot  = 1'b0;
    case (state_q)
      SYNC: begin
        // Only a right->left edge gives a clean frame boundary to lock onto.
        if (left_start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (ws_edge) begin
          clear = 1'b1;
          if (cnt >= DATA_N) begin
            close_left  = ~ws_prev;
            close_right = ws_prev;
          end else begin
            short_slot = 1'b1;
          end
        end else if (rise) begin
          step = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Bits past DATA_W in a slot are counted but not captured.
  assign shift_en = step & (cnt < DATA_N);
  // Closing right always coincides with ws_i=0, i.e. the frame end.
  assign complete = close_right & ~bad;

  // Slot datapath: bit counter, shift register, left staging, bad-frame flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt       <= '0;
      shreg     <= '0;
      left_hold <= '0;
      bad       <= 1'b0;
    end else begin
      if (clear)                        cnt <= '0;
      else if (step && cnt != CNT_MAX)  cnt <= cnt + 8'd1;

      if (clear)         shreg <= '0;
      else if (shift_en) shreg <= {shreg[DATA_W-2:0], sd_s};

      if (close_left) left_hold <= shreg;

      // A new frame starts clean; a short slot poisons the rest of it.
      if (left_start)      bad <= 1'b0;
      else if (short_slot) bad <= 1'b1;
    end
  end

  // Output pair, handshake and status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pair_q      <= '0;
      valid_o     <= 1'b0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= short_slot;
      // Accept-and-replace in the same cycle is not an overrun.
      overrun_o   <= complete & valid_o & ~ready_i;
      if (complete) begin
        pair_q  <= '{left: left_hold, right: shreg};
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  assign left_o  = pair_q.left;
  assign right_o = pair_q.right;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives SCK/WS/SD directly (8 clk per SCK period) and
// checks captured pairs against a bit-stream model of the I2S framing rules.
module tb_i2s_rx;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst, sck, ws, sd, ready;
  logic          valid, ovr, ferr;
  logic [DW-1:0] lo, ro;

  always #5 clk = ~clk;

  i2s_rx #(.DATA_W(DW), .SLOT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws), .sd_i(sd),
    .left_o(lo), .right_o(ro), .valid_o(valid), .ready_i(ready),
    .overrun_o(ovr), .frame_err_o(ferr)
  );

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (bit-stream level) ----------------
  typedef struct packed { logic [DW-1:0] l; logic [DW-1:0] r; } pair_t;
  pair_t         expq[$];
  bit            m_sync, l_ok, m_done;
  logic          m_ws;
  logic          m_bitq[$];
  logic [DW-1:0] l_val;
  int            exp_err = 0;

  function automatic logic [DW-1:0] first_bits();
    logic [DW-1:0] v = '0;
    for (int i = 0; i < DW; i++) v[DW-1-i] = m_bitq[i];
    return v;
  endfunction

  task automatic model_reset();
    m_sync = 0; l_ok = 0; m_ws = 1'b1; m_done = 0;
    m_bitq.delete();
    expq.delete();
  endtask

  // One SCK period carrying (w, d): a change of w closes the previous slot,
  // whose usable bits are those sent after its own change period.
  task automatic model_step(input logic w, input logic d);
    m_done = 0;
    if (w !== m_ws) begin
      if (m_sync) begin
        if (m_bitq.size() < DW) begin
          exp_err++;
          if (m_ws == 1'b0) l_ok = 0;
        end else if (m_ws == 1'b0) begin
          l_ok = 1; l_val = first_bits();
        end else if (l_ok) begin
          expq.push_back('{l: l_val, r: first_bits()});
          m_done = 1;
        end
      end
      if (w == 1'b0) m_sync = 1;
      m_ws = w;
      m_bitq.delete();
    end else if (m_sync && m_bitq.size() < 300) begin
      m_bitq.push_back(d);
    end
  endtask

  // ---------------- monitor ----------------
  bit            mon_en = 0;
  int            acc_cnt = 0, err_cyc = 0, ovr_cyc = 0;
  logic [DW-1:0] last_l, last_r;
  pair_t         mon_p;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (ferr) err_cyc++;
      if (ovr) begin
        ovr_cyc++;
        check("ovr_has_pending_pair", 64'(expq.size() >= 2), 1);
        if (expq.size() >= 2) void'(expq.pop_front());
      end
      if (valid && ready) begin
        acc_cnt++;
        last_l = lo; last_r = ro;
        if (expq.size() == 0) check("valid_without_frame", expq.size(), 1);
        else begin
          mon_p = expq.pop_front();
          check("acc_left", lo, mon_p.l);
          check("acc_right", ro, mon_p.r);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit lat_chk = 1, edge_rdy = 0, rnd_rdy = 0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic period(input logic w, input logic d, input bit chk);
    model_step(w, d);
    if (rnd_rdy) ready = ($urandom_range(0, 3) != 0);
    sck = 1'b0; ws = w; sd = d;
    repeat (4) tick();
    sck = 1'b1;
    if (chk && edge_rdy) ready = 1'b1;
    if (chk && lat_chk && ready && !edge_rdy) check("pre_edge_valid", valid, 0);
    tick();
    if (chk && lat_chk && ready && !edge_rdy) check("valid_latency", valid, m_done);
    if (chk && edge_rdy) ready = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("reset_outputs", {lo, ro, valid, ovr, ferr}, 0);
  endtask

  // Left slot's change period was already sent; send the rest of it, the
  // right slot, and the closing right->left change period.
  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input int llen, input int rlen, input int rst_l, input int rst_r);
    logic d;
    for (int i = 1; i < llen; i++) begin
      if (i == rst_l) pulse_reset();
      if (i <= DW) d = l[DW-i]; else d = rbit();
      period(1'b0, d, 0);
    end
    for (int i = 0; i < rlen; i++) begin
      if (i == rst_r) pulse_reset();
      if (i == 0 || i > DW) d = rbit(); else d = r[DW-i];
      period(1'b1, d, 0);
    end
    period(1'b0, rbit(), 1);
  endtask

  typedef struct {
    logic [DW-1:0] l, r;
    int            llen, rlen;
    int            ev, ee;
  } vec_t;
  vec_t tv[9];

  int a0, e0, o0, ll, rl;

  initial begin
    tv[0] = '{24'hA5A5A5, 24'h5A5A5A,  32, 32, 1, 0};
    tv[1] = '{24'h123456, 24'hABCDEF,  32, 32, 1, 0};
    tv[2] = '{24'hFFFFFF, 24'h000000,  25, 25, 1, 0};
    tv[3] = '{24'h800001, 24'h7FFFFE,  24, 32, 0, 1};
    tv[4] = '{24'h0ABCDE, 24'h0FEDCB,  11, 32, 0, 1};
    tv[5] = '{24'h0F0F0F, 24'hF0F0F0,  32, 11, 0, 1};
    tv[6] = '{24'h111111, 24'h222222,  11, 11, 0, 2};
    tv[7] = '{24'hC3C3C3, 24'h3C3C3C, 300, 33, 1, 0};
    tv[8] = '{24'h654321, 24'hFEDCBA,  32, 32, 1, 0};

    rst = 1'b1; sck = 1'b0; ws = 1'b1; sd = 1'b0; ready = 1'b1;
    model_reset();
    repeat (3) tick();
    check("reset_state", {lo, ro, valid, ovr, ferr}, 0);
    rst = 1'b0;
    mon_en = 1;

    // Partial right slot after reset is never output; lock on the WS fall.
    for (int i = 0; i < 12; i++) period(1'b1, rbit(), 0);
    period(1'b0, rbit(), 1);

    // Table of frames with ready held high.
    for (int i = 0; i < 9; i++) begin
      a0 = acc_cnt; e0 = err_cyc;
      frame(tv[i].l, tv[i].r, tv[i].llen, tv[i].rlen, -1, -1);
      check($sformatf("row%0d_valid", i), acc_cnt - a0, tv[i].ev);
      check($sformatf("row%0d_err", i), err_cyc - e0, tv[i].ee);
      if (tv[i].ev != 0) begin
        check($sformatf("row%0d_left", i), last_l, tv[i].l);
        check($sformatf("row%0d_right", i), last_r, tv[i].r);
      end
    end
    check("table_no_overrun", ovr_cyc, 0);

    // Reset mid-right-slot: that frame is dropped, the next one comes out.
    a0 = acc_cnt; e0 = err_cyc;
    frame(24'h246801, 24'h13579B, 32, 32, -1, 10);
    check("rst_right_no_valid", acc_cnt - a0, 0);
    check("rst_right_no_err", err_cyc - e0, 0);
    frame(24'h777777, 24'h888888, 32, 32, -1, -1);
    check("rst_right_resume", acc_cnt - a0, 1);
    check("rst_right_left", last_l, 24'h777777);

    // Two completions with no consumer: one overrun, newest pair held.
    ready = 1'b0; o0 = ovr_cyc;
    frame(24'h111111, 24'h222222, 32, 32, -1, -1);
    frame(24'h333333, 24'h444444, 32, 32, -1, -1);
    check("overrun_once", ovr_cyc - o0, 1);
    check("ovr_hold_pair", {valid, lo, ro}, {1'b1, 24'h333333, 24'h444444});
    repeat (20) tick();
    check("ovr_hold_stable", {valid, lo, ro}, {1'b1, 24'h333333, 24'h444444});
    a0 = acc_cnt;
    ready = 1'b1;
    tick(); tick();
    check("ovr_accept", acc_cnt - a0, 1);
    check("valid_drop", valid, 0);

    // Accept coinciding with a completion: valid stays up with new data.
    ready = 1'b0;
    frame(24'h13579B, 24'h2468AC, 32, 32, -1, -1);
    check("held_before_edge", valid, 1);
    o0 = ovr_cyc; a0 = acc_cnt;
    edge_rdy = 1;
    frame(24'hBEEF01, 24'hC0FFEE, 32, 32, -1, -1);
    edge_rdy = 0;
    check("swap_valid_left_right", {valid, lo, ro}, {1'b1, 24'hBEEF01, 24'hC0FFEE});
    check("swap_no_overrun", ovr_cyc - o0, 0);
    check("swap_old_accepted", acc_cnt - a0, 1);
    ready = 1'b1;
    tick(); tick();

    // Reset mid-left-slot: no output until a full frame follows.
    a0 = acc_cnt;
    frame(24'h9ABCDE, 24'h765432, 32, 32, 20, -1);
    check("rst_left_no_valid", acc_cnt - a0, 0);
    frame(24'h0C0FFE, 24'hF00D42, 32, 32, -1, -1);
    check("rst_left_resume", acc_cnt - a0, 1);
    check("rst_left_right", last_r, 24'hF00D42);

    // Randomised frames, slot lengths and consumer back-pressure.
    lat_chk = 0; rnd_rdy = 1;
    for (int i = 0; i < 24; i++) begin
      ll = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 24)) : int'($urandom_range(25, 40));
      rl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 24)) : int'($urandom_range(25, 40));
      frame(DW'($urandom), DW'($urandom), ll, rl, -1, -1);
    end
    rnd_rdy = 0; ready = 1'b1;
    repeat (4) tick();

    check("frame_err_total", err_cyc, exp_err);
    check("queue_drained", expq.size(), 0);
    check("valid_idle_at_end", valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
